line_fetch_axi_reader: RTL and testbench
========================================

Name: line_fetch_axi_reader

Overview:
- Read responder for the undistort cache-miss interface; sits between the undistort cache and the AXI4 interconnect to frame DDR.
- Samples `r_request`/`r_addr`, converts the {row, 32-pixel block} address into one 2-beat INCR burst of 128-bit words, and returns the data as `r_data`/`r_valid`/`r_last`.
- Enforces a cooldown after each burst so the registered request can drop once the cache marks the line valid.

Parameters:
- FRAME_BASE, 32'h0100_0000, byte address of frame pixel (0,0).
- LINE_STRIDE, 1280, bytes per image row (8-bit pixels).
- FRAME_H, 720, valid rows 0..FRAME_H-1.
- BLOCKS_PER_ROW, 40, valid column blocks 0..39 (32 px each).
- BURST_LEN, 2, beats per fetch (128-bit beats).
- COOLDOWN, 2, idle cycles after last beat before resampling a request.

Ports:
- clk  in  1  system clock (AXI4 clock domain)
- rst  in  1  reset; synchronous, active-high
- r_request  in  1  level request from cache; held while a miss persists
- r_addr  in  16  [15:6] row, [5:0] 32-pixel column block
- r_data  out  128  returned pixels, byte k = pixel (block*32 + beat*16 + k)
- r_valid  out  1  r_data valid, one cycle per beat
- r_last  out  1  final beat of the fetch
- rd_err  out  1  sticky: a non-OKAY rresp was seen, or rlast was misplaced
- range_err  out  1  one-cycle pulse: the request was dropped as out of range
- m_axi_araddr  out  32  burst byte address
- m_axi_arlen  out  8  constant BURST_LEN-1
- m_axi_arsize  out  3  constant 3'd4 (16 B)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  address accepted
- m_axi_rdata  in  128  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last read beat
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read ready

Behaviour:
- Reset values:
  - Outputs: r_valid=0, r_last=0, r_data=0, rd_err=0, range_err=0, m_axi_arvalid=0, m_axi_rready=0, m_axi_araddr=0.
  - Internal: state=IDLE.
- FSM states: IDLE, ADDR, DATA, COOL.
- IDLE: if r_request=1, register r_addr.
  - Row>=FRAME_H or block>=BLOCKS_PER_ROW: pulse range_err next cycle and go to COOL; no AXI traffic.
  - Otherwise: araddr = FRAME_BASE + row*LINE_STRIDE + block*32 (32-bit unsigned, computed from the registered address), arvalid=1 next cycle, go to ADDR.
- ADDR: hold arvalid, araddr and the latched address stable until the arready&arvalid handshake. Then arvalid=0, rready=1, beat counter=0, go to DATA.
- DATA: rready stays high, with no backpressure from the cache.
  - Each rvalid beat: r_data<=rdata, r_valid<=1, r_last<=rlast, registered one cycle.
  - Beat counter increments per beat.
  - rresp!=0: set rd_err; data is still forwarded.
  - rlast on beat counter!=BURST_LEN-1: set rd_err, end the burst there.
  - rlast absent on beat counter==BURST_LEN-1: set rd_err, keep accepting beats until rlast, forwarding each.
  - On the rlast beat: rready=0 next cycle, load the cooldown counter with COOLDOWN, go to COOL.
- COOL: count down COOLDOWN cycles, ignoring r_request, then go to IDLE. The out-of-range path also passes through COOL.
- Request contract:
  - r_request is level-sensitive and sampled only in IDLE.
  - r_addr changing while not in IDLE is ignored; the latched address is used.
  - r_request still high after COOL: a new fetch of the current r_addr is issued. Redundant refetch is acceptable; the data is identical.
- Latency:
  - r_request high in IDLE -> arvalid high 1 cycle later (with arready tied high, the handshake completes on that cycle).
  - Each R beat -> r_valid 1 cycle later.
- Only one burst is outstanding at any time; no AR is issued while in DATA.
- Reset mid-operation: next state IDLE, arvalid/rready drop, and rd_err clears. rst is asserted only together with the interconnect reset, so no stale beats are expected after it.
- Width rule: row*LINE_STRIDE is computed as (row<<10)+(row<<8) when LINE_STRIDE=1280, otherwise as a generic multiply; the result is at least 21 bits and zero-extended to 32 before the add.

Decomposition:
- Shared package `undistort_pkg` holds the frame-geometry constants shared with undistort: FRAME_W=1280, FRAME_H=720, BLOCK_PIX=32, BEAT_BYTES=16, and the ADDR_WIDTH=16 field split (ROW_MSB=15, ROW_LSB=6).
- It also holds the state enum {IDLE, ADDR, DATA, COOL} and AXI constants (BURST_INCR, RESP_OKAY).
- One natural sub-module, `line_addr_calc`: registered {row, block} -> byte address with range check, one-cycle latency.

Test Plan:
- Row 3, block 5, FRAME_BASE 0x0100_0000, arready=1 -> one AR with araddr 0x0100_0FA0, arlen=1, arsize=4, arburst=1; two R beats D0, D1 -> r_valid on 2 cycles, r_last=1 only with D1, data byte-exact.
- Row 719, block 39 -> araddr 0x010E_0FE0; row 720, block 0 -> no arvalid, range_err one-cycle pulse, FSM back in IDLE after COOLDOWN+1 cycles.
- arready held low 5 cycles with r_addr toggling meanwhile -> arvalid high and araddr constant for all 5 cycles; the fetch uses the originally latched address.
- Beat 0 with rresp=2'b10 (SLVERR) -> rd_err rises and stays 1; both beats still forwarded; rd_err clears only on rst.
- Premature rlast on beat 0 -> burst ends, r_last=1 on that beat, rd_err=1; r_request held high -> next AR exactly COOLDOWN+2 cycles after the rlast beat.
- rst pulsed during DATA after beat 0 -> next cycle arvalid=0, rready=0, r_valid=0, state IDLE; a new request after reset produces a normal burst.

Source files
------------

// File: rtl/undistort_pkg.sv
// Frame geometry, request address split and AXI constants shared by the
// undistort cache and its line fetcher.
package undistort_pkg;

  localparam int FRAME_W    = 1280;
  localparam int FRAME_H    = 720;
  localparam int BLOCK_PIX  = 32;
  localparam int BEAT_BYTES = 16;

  localparam int ADDR_WIDTH = 16;
  localparam int ROW_MSB    = 15;
  localparam int ROW_LSB    = 6;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    COOL
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/line_addr_calc.sv
// Converts a {row, 32-pixel block} request into the burst byte address and
// flags requests outside the frame; the address is registered on i_load.
module line_addr_calc
  import undistort_pkg::ADDR_WIDTH;
  import undistort_pkg::ROW_MSB;
  import undistort_pkg::ROW_LSB;
  import undistort_pkg::BLOCK_PIX;
#(
  parameter logic [31:0] FRAME_BASE     = 32'h0100_0000,
  parameter int          LINE_STRIDE    = 1280,
  parameter int          FRAME_H        = 720,
  parameter int          BLOCKS_PER_ROW = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_in_range,
  output logic [31:0]           o_araddr
);

  localparam int ROW_W     = ROW_MSB - ROW_LSB + 1;
  localparam int BLK_W     = ROW_LSB;
  localparam int BLK_SHIFT = $clog2(BLOCK_PIX);

  logic [ROW_W-1:0] w_row;
  logic [BLK_W-1:0] w_blk;
  logic [31:0]      w_row_off;
  logic [31:0]      w_blk_off;
  logic [31:0]      w_addr;

  assign w_row = i_addr[ROW_MSB:ROW_LSB];
  assign w_blk = i_addr[ROW_LSB-1:0];

  assign o_in_range = (32'(w_row) < 32'(FRAME_H)) &&
                      (32'(w_blk) < 32'(BLOCKS_PER_ROW));

  // The 1280-byte stride is a shift-add; the 21-bit sum covers row 1023.
  generate
    if (LINE_STRIDE == 1280) begin : g_shift_add
      logic [20:0] w_prod;
      assign w_prod    = {1'b0, w_row, 10'b0} + {3'b0, w_row, 8'b0};
      assign w_row_off = {11'b0, w_prod};
    end else begin : g_mult
      assign w_row_off = 32'(w_row) * 32'(LINE_STRIDE);
    end
  endgenerate

  assign w_blk_off = {{(32-BLK_W-BLK_SHIFT){1'b0}}, w_blk, {BLK_SHIFT{1'b0}}};
  assign w_addr    = FRAME_BASE + w_row_off + w_blk_off;

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_araddr <= '0;
    end else if (i_load) begin
      o_araddr <= w_addr;
    end
  end

endmodule

// File: rtl/line_fetch_axi_reader.sv
// Cache-miss read responder: one 2-beat INCR burst per request, registered
// beat forwarding, sticky protocol error flag and a post-burst cooldown.
module line_fetch_axi_reader
  import undistort_pkg::state_t;
  import undistort_pkg::IDLE;
  import undistort_pkg::ADDR;
  import undistort_pkg::DATA;
  import undistort_pkg::COOL;
  import undistort_pkg::BURST_INCR;
  import undistort_pkg::RESP_OKAY;
  import undistort_pkg::BEAT_BYTES;
  import undistort_pkg::ADDR_WIDTH;
#(
  parameter logic [31:0] FRAME_BASE     = 32'h0100_0000,
  parameter int          LINE_STRIDE    = undistort_pkg::FRAME_W,
  parameter int          FRAME_H        = undistort_pkg::FRAME_H,
  parameter int          BLOCKS_PER_ROW = 40,
  parameter int          BURST_LEN      = 2,
  parameter int          COOLDOWN       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_request,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [127:0]          r_data,
  output logic                  r_valid,
  output logic                  r_last,
  output logic                  rd_err,
  output logic                  range_err,
  output logic [31:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [127:0]          m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [7:0] BEAT_CAP  = 8'(BURST_LEN);
  localparam logic [7:0] COOL_INIT = 8'(COOLDOWN);

  state_t     r_state;
  logic [7:0] r_beat;
  logic [7:0] r_cool;
  logic       w_in_range;
  logic       w_load;

  assign w_load = (r_state == IDLE) && r_request && w_in_range;

  line_addr_calc #(
    .FRAME_BASE     (FRAME_BASE),
    .LINE_STRIDE    (LINE_STRIDE),
    .FRAME_H        (FRAME_H),
    .BLOCKS_PER_ROW (BLOCKS_PER_ROW)
  ) u_addr_calc (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_addr     (r_addr),
    .o_in_range (w_in_range),
    .o_araddr   (m_axi_araddr)
  );

  assign m_axi_arlen   = LAST_BEAT;
  assign m_axi_arsize  = 3'($clog2(BEAT_BYTES));
  assign m_axi_arburst = BURST_INCR;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_beat        <= '0;
      r_cool        <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      rd_err        <= 1'b0;
      range_err     <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      range_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_request) begin
            if (w_in_range) begin
              m_axi_arvalid <= 1'b1;
              r_state       <= ADDR;
            end else begin
              range_err <= 1'b1;
              r_cool    <= COOL_INIT;
              r_state   <= COOL;
            end
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            r_beat        <= '0;
            r_state       <= DATA;
          end
        end
        DATA: begin
          if (m_axi_rvalid) begin
            r_data  <= m_axi_rdata;
            r_valid <= 1'b1;
            r_last  <= m_axi_rlast;
            // Any rresp error or an rlast not on the final beat is sticky.
            if (m_axi_rresp != RESP_OKAY) rd_err <= 1'b1;
            if (m_axi_rlast != (r_beat == LAST_BEAT)) rd_err <= 1'b1;
            if (r_beat < BEAT_CAP) r_beat <= r_beat + 8'd1;
            if (m_axi_rlast) begin
              m_axi_rready <= 1'b0;
              r_cool       <= COOL_INIT;
              r_state      <= COOL;
            end
          end
        end
        COOL: begin
          if (r_cool <= 8'd1) r_state <= IDLE;
          else r_cool <= r_cool - 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fetch_axi_reader.sv
// Scoreboard bench: stimulus pushes expected AR addresses, beats and range
// pulses into queues; a negedge monitor pops and compares them.
module tb_line_fetch_axi_reader;

  localparam logic [31:0] FRAME_BASE = 32'h0100_0000;
  localparam int STRIDE    = 1280;
  localparam int FH        = 720;
  localparam int BPR       = 40;
  localparam int BURST_LEN = 2;
  localparam int COOLDOWN  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         r_request;
  logic [15:0]  r_addr;
  logic [127:0] r_data;
  logic         r_valid, r_last, rd_err, range_err;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid, m_axi_arready;
  logic [127:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  line_fetch_axi_reader dut (
    .clk           (clk),
    .rst           (rst),
    .r_request     (r_request),
    .r_addr        (r_addr),
    .r_data        (r_data),
    .r_valid       (r_valid),
    .r_last        (r_last),
    .rd_err        (rd_err),
    .range_err     (range_err),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } beat_t;

  logic [31:0] exp_ar[$];
  beat_t       exp_beat[$];
  int          exp_range  = 0;
  logic        exp_rd_err = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input int row, input int blk);
    longint a;
    a = longint'(FRAME_BASE) + longint'(row) * STRIDE + longint'(blk) * 32;
    return a[31:0];
  endfunction

  function automatic bit in_range(input int row, input int blk);
    return (row < FH) && (blk < BPR);
  endfunction

  // Monitor: every DUT presentation is matched against the queued expectation.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (m_axi_arvalid) begin
      if (exp_ar.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ar: araddr=%0h, expected no request", m_axi_araddr);
      end else begin
        check("araddr", m_axi_araddr, exp_ar[0]);
        if (m_axi_arready) begin
          check("arlen", m_axi_arlen, BURST_LEN - 1);
          check("arsize", m_axi_arsize, 3'd4);
          check("arburst", m_axi_arburst, 2'b01);
          void'(exp_ar.pop_front());
        end
      end
    end
    if (r_valid) begin
      if (exp_beat.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: r_data=%0h, expected no beat", r_data);
      end else begin
        b = exp_beat.pop_front();
        check("r_data", r_data, b.data);
        check("r_last", r_last, b.last);
      end
    end else if (r_last) begin
      checks++; errors++;
      $display("FAIL r_last_without_valid: r_last=1, expected 0");
    end
    if (range_err) begin
      checks++;
      if (exp_range == 0) begin
        errors++;
        $display("FAIL unexpected_range_err: range_err=1, expected 0");
      end else begin
        exp_range--;
      end
    end
  end

  task automatic wait_arvalid(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m_axi_arvalid) begin
        ok = 1'b1;
        n  = i;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arvalid=0 after 20 cycles, expected 1");
    end
  endtask

  task automatic send_beats(input int last_pos, input int err_beat);
    for (int i = 0; i <= last_pos; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.last = (i == last_pos);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = b.data;
      m_axi_rlast  = b.last;
      m_axi_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      exp_beat.push_back(b);
      if (i == err_beat) exp_rd_err = 1'b1;
      @(posedge clk); #1;
    end
    if (last_pos != BURST_LEN - 1) exp_rd_err = 1'b1;
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
  endtask

  task automatic fetch(input int row, input int blk, input int ar_delay, input int last_pos,
                       input int err_beat, input bit toggle, input bit refetch);
    logic [31:0] a;
    bit ok;
    int n;
    a = model_addr(row, blk);
    r_addr = {row[9:0], blk[5:0]};
    if (!in_range(row, blk)) begin
      exp_range++;
      r_request = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (range_err) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL range_timeout: range_err=0 after 10 cycles, expected 1");
      end
      @(posedge clk); #1;
      r_request = 1'b0;
      repeat (COOLDOWN + 2) @(posedge clk);
      #1;
      return;
    end
    exp_ar.push_back(a);
    m_axi_arready = (ar_delay == 0);
    r_request = 1'b1;
    wait_arvalid(ok, n);
    if (!ok) begin
      r_request = 1'b0;
      m_axi_arready = 1'b1;
      return;
    end
    check("ar_latency", n, 2);
    repeat (ar_delay) begin
      @(posedge clk); #1;
      r_request = 1'b0;
      if (toggle) r_addr = 16'($urandom);
      check("arvalid_hold", m_axi_arvalid, 1'b1);
    end
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    r_request = 1'b0;
    check("rready_after_ar", m_axi_rready, 1'b1);
    send_beats(last_pos, err_beat);
    check("rready_after_last", m_axi_rready, 1'b0);
    check("rd_err", rd_err, exp_rd_err);
    if (refetch) begin
      exp_ar.push_back(a);
      r_addr = {row[9:0], blk[5:0]};
      r_request = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (m_axi_arvalid) begin n = i; break; end
      end
      check("refetch_gap", n, COOLDOWN + 2);
      @(posedge clk); #1;
      r_request = 1'b0;
      check("rready_refetch", m_axi_rready, 1'b1);
      send_beats(BURST_LEN - 1, -1);
      check("rd_err_refetch", rd_err, exp_rd_err);
    end
    repeat (COOLDOWN + 2) @(posedge clk);
    #1;
  endtask

  task automatic range_hold();
    logic [9:0] mask;
    logic [9:0] exp_mask;
    mask = '0;
    exp_mask = '0;
    for (int k = 0; k < 3; k++) exp_mask[2 + k * (COOLDOWN + 1)] = 1'b1;
    exp_range += 3;
    r_addr = {10'd720, 6'd0};
    r_request = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (range_err) mask[n] = 1'b1;
    end
    @(posedge clk); #1;
    r_request = 1'b0;
    check("range_pulse_pattern", mask, exp_mask);
    repeat (COOLDOWN + 2) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_data(input int row, input int blk);
    bit ok;
    int n;
    beat_t b;
    exp_ar.push_back(model_addr(row, blk));
    r_addr = {row[9:0], blk[5:0]};
    m_axi_arready = 1'b1;
    r_request = 1'b1;
    wait_arvalid(ok, n);
    @(posedge clk); #1;
    r_request = 1'b0;
    b.data = {$urandom, $urandom, $urandom, $urandom};
    b.last = 1'b0;
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = b.data;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
    exp_beat.push_back(b);
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd_err = 1'b0;
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1;
    r_request = 1'b0;
    r_addr = '0;
    m_axi_arready = 1'b1;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_r_valid", r_valid, 1'b0);
    check("reset_r_last", r_last, 1'b0);
    check("reset_r_data", r_data, 128'd0);
    check("reset_rd_err", rd_err, 1'b0);
    check("reset_range_err", range_err, 1'b0);
    check("reset_arvalid", m_axi_arvalid, 1'b0);
    check("reset_rready", m_axi_rready, 1'b0);
    check("reset_araddr", m_axi_araddr, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    fetch(3, 5, 0, 1, -1, 1'b0, 1'b0);
    fetch(719, 39, 0, 1, -1, 1'b0, 1'b0);
    range_hold();
    fetch(0, 40, 0, 1, -1, 1'b0, 1'b0);
    fetch(100, 20, 5, 1, -1, 1'b1, 1'b0);
    fetch(10, 1, 0, 1, 0, 1'b0, 1'b0);
    fetch(11, 2, 0, 1, -1, 1'b0, 1'b0);
    fetch(12, 3, 0, 0, -1, 1'b0, 1'b1);
    fetch(13, 4, 0, 2, -1, 1'b0, 1'b0);
    reset_mid_data(50, 7);
    fetch(51, 8, 0, 1, -1, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      int row, blk, dly, eb;
      row = $urandom_range(0, 740);
      blk = $urandom_range(0, 45);
      dly = $urandom_range(0, 3);
      eb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      fetch(row, blk, dly, 1, eb, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("ar_queue_drained", exp_ar.size(), 0);
    check("beat_queue_drained", exp_beat.size(), 0);
    check("range_queue_drained", exp_range, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
